// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU datapath and control.
// Holds the mult/div sequencer states and the sign helper.
package cpu_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MULT_RUN = 3'd1,
        DIV_RUN  = 3'd2,
        FIX_SIGN = 3'd3,
        FINISH   = 3'd4
    } md_state_t;

    // MemToReg sources for mfhi / mflo
    localparam logic [1:0] MEMTOREG_HI = 2'd2;
    localparam logic [1:0] MEMTOREG_LO = 2'd3;

    function automatic logic [MD_WIDTH-1:0] cond_neg(
        input logic [MD_WIDTH-1:0] v,
        input logic                neg
    );
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide engine with Hi/Lo result registers.
// One shared add/subtract datapath serves both shift-add and restoring divide.
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    md_state_t state, state_nx;

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               neg_res;
    logic               neg_r;
    logic               is_div;
    logic               dz;

    logic               last;
    logic [WIDTH-1:0]   ain;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_m;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   fix_lo;
    logic [WIDTH-1:0]   fix_hi_m;
    logic [WIDTH-1:0]   fix_hi_d;

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        a_mag = cond_neg(a, a[WIDTH-1]);
        b_mag = cond_neg(b, b[WIDTH-1]);

        // divide works on the remainder after its one-bit left shift
        ain = is_div ? acc[2*WIDTH-2:WIDTH-1] : acc[2*WIDTH-1:WIDTH];
        sum = is_div ? ({1'b0, ain} - {1'b0, opb})
                     : ({1'b0, ain} + {1'b0, opb});

        acc_m = acc[0] ? {sum, acc[WIDTH-1:1]}
                       : {1'b0, acc[2*WIDTH-1:1]};
        acc_d = sum[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                           : {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        // 2W negate split as {~hi + (lo==0), -lo}
        fix_lo   = cond_neg(acc[WIDTH-1:0], neg_res);
        fix_hi_m = neg_res
                 ? (~acc[2*WIDTH-1:WIDTH]
                    + {{(WIDTH-1){1'b0}}, (acc[WIDTH-1:0] == '0)})
                 : acc[2*WIDTH-1:WIDTH];
        fix_hi_d = cond_neg(acc[2*WIDTH-1:WIDTH], neg_r);
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_mult)
                    state_nx = MULT_RUN;
                else if (start_div)
                    state_nx = (b == '0) ? FINISH : DIV_RUN;
            end
            MULT_RUN, DIV_RUN: begin
                busy = 1'b1;
                if (last)
                    state_nx = FIX_SIGN;
            end
            FIX_SIGN: begin
                busy     = 1'b1;
                state_nx = FINISH;
            end
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign div_zero = done & dz;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            opb     <= '0;
            neg_res <= 1'b0;
            neg_r   <= 1'b0;
            is_div  <= 1'b0;
            dz      <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start_mult) begin
                        acc     <= {{WIDTH{1'b0}}, a_mag};
                        opb     <= b_mag;
                        neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
                        is_div  <= 1'b0;
                        dz      <= 1'b0;
                        cnt     <= '0;
                    end else if (start_div) begin
                        if (b == '0) begin
                            dz <= 1'b1;
                        end else begin
                            acc     <= {{WIDTH{1'b0}}, a_mag};
                            opb     <= b_mag;
                            neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r   <= a[WIDTH-1];
                            is_div  <= 1'b1;
                            dz      <= 1'b0;
                            cnt     <= '0;
                        end
                    end
                end
                MULT_RUN: begin
                    acc <= acc_m;
                    cnt <= cnt + 1'b1;
                end
                DIV_RUN: begin
                    acc <= acc_d;
                    cnt <= cnt + 1'b1;
                end
                FIX_SIGN: begin
                    lo <= fix_lo;
                    hi <= is_div ? fix_hi_d : fix_hi_m;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for the mult/div engine.
// Checks results, latency, busy span, divide-by-zero and reset abort.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_run;
    int n_fail;

    mult_div_unit dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // lat counts edges from the start edge to the first cycle showing done
    task automatic run_op(input logic m, input logic d,
                          input logic [31:0] av, input logic [31:0] bv,
                          input int inj, output int lat,
                          output int bcnt, output logic dzs);
        logic seen;
        @(negedge clock);
        a = av;
        b = bv;
        start_mult = m;
        start_div  = d;
        lat  = 0;
        bcnt = 0;
        dzs  = 1'b0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            start_mult = 1'b0;
            start_div  = (lat == inj);
            a = $urandom;
            b = $urandom;
            if (busy) bcnt++;
            if (done) begin
                seen = 1'b1;
                dzs  = div_zero;
            end
        end
        start_div = 1'b0;
        if (!seen) check("timeout", 32'd0, 32'd1);
    endtask

    int   lat;
    int   bc;
    logic dzs;
    int   dcnt;

    initial begin
        n_run = 0;
        n_fail = 0;
        reset = 1'b1;
        start_mult = 1'b0;
        start_div = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);
        reset = 1'b0;

        // 7 * -3 = -21
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -1, lat, bc, dzs);
        check("m1_hi", hi, 32'hFFFF_FFFF);
        check("m1_lo", lo, 32'hFFFF_FFEB);
        check("m1_lat", lat, 34);
        check("m1_busy", bc, 33);
        check("m1_dz", {31'd0, dzs}, 32'd0);
        @(negedge clock);
        check("m1_done_1cy", {31'd0, done}, 32'd0);

        // -7 / 2 = -3 rem -1
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, lat, bc, dzs);
        check("d1_lo", lo, 32'hFFFF_FFFD);
        check("d1_hi", hi, 32'hFFFF_FFFF);
        check("d1_dz", {31'd0, dzs}, 32'd0);
        check("d1_lat", lat, 34);

        // divide by zero leaves hi/lo alone
        run_op(1'b0, 1'b1, 32'd100, 32'd0, -1, lat, bc, dzs);
        check("dz_flag", {31'd0, dzs}, 32'd1);
        check("dz_lat", lat, 1);
        check("dz_busy", bc, 0);
        check("dz_hi", hi, 32'hFFFF_FFFF);
        check("dz_lo", lo, 32'hFFFF_FFFD);

        // most-negative operands
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1, lat, bc, dzs);
        check("mn_m_hi", hi, 32'h4000_0000);
        check("mn_m_lo", lo, 32'h0);
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, bc, dzs);
        check("mn_d_lo", lo, 32'h8000_0000);
        check("mn_d_hi", hi, 32'h0);

        // 100 / -7 = -14 rem 2
        run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, -1, lat, bc, dzs);
        check("d2_lo", lo, 32'hFFFF_FFF2);
        check("d2_hi", hi, 32'd2);

        // start_div mid-multiply must be ignored
        run_op(1'b1, 1'b0, 32'd3, 32'd5, 10, lat, bc, dzs);
        check("ig_hi", hi, 32'h0);
        check("ig_lo", lo, 32'd15);
        check("ig_lat", lat, 34);
        repeat (3) @(negedge clock);
        check("ig_idle", {31'd0, busy}, 32'd0);

        // simultaneous starts: multiply wins (-4*5 = -20)
        run_op(1'b1, 1'b1, 32'hFFFF_FFFC, 32'd5, -1, lat, bc, dzs);
        check("sim_hi", hi, 32'hFFFF_FFFF);
        check("sim_lo", lo, 32'hFFFF_FFEC);
        check("sim_dz", {31'd0, dzs}, 32'd0);

        // reset during a divide aborts it
        @(negedge clock);
        a = 32'd1000;
        b = 32'd7;
        start_div = 1'b1;
        @(negedge clock);
        start_div = 1'b0;
        repeat (18) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("ra_hi", hi, 32'h0);
        check("ra_lo", lo, 32'h0);
        check("ra_busy", {31'd0, busy}, 32'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dcnt++;
        end
        check("ra_nodone", dcnt, 0);

        run_op(1'b1, 1'b0, 32'd6, 32'd7, -1, lat, bc, dzs);
        check("ra_m_lo", lo, 32'd42);
        check("ra_m_hi", hi, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
